// File: rtl/usb_uart_tx_arb.sv
// Shares the usb_uart transmit byte port among NREQ producers using line-granular
// round-robin, pacing writes against uart_busy and discarding traffic without a host.
module usb_uart_tx_arb #(
  parameter int unsigned NREQ         = 2,
  parameter int unsigned BURST_MAX    = 64,
  parameter int unsigned IDLE_TIMEOUT = 4800,
  parameter bit          DROP_NO_HOST = 1'b1
) (
  input  logic              clk_48mhz,
  input  logic              resetq,
  input  logic              host_presence,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              uart_wr,
  output logic [7:0]        uart_tx_data,
  input  logic              uart_busy,
  output logic [1:0]        grant_id,
  output logic              grant_active,
  output logic [15:0]       drop_count
);

  localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StGrant, StPace1, StPace2} state_e;

  state_e           state_q;
  logic [1:0]       grant_q;
  logic [1:0]       rr_q;
  logic [7:0]       burst_q;
  logic [IdleW-1:0] idle_q;
  logic             release_q;
  logic             wr_q;
  logic [7:0]       data_q;
  logic [15:0]      drop_q;

  logic        drop_mode;
  logic        stall_mode;
  logic [3:0]  valid4;
  logic [3:0]  ready4;
  logic [31:0] data4;
  logic [7:0]  grant_byte;
  logic        grant_xfer;
  logic        pick_found;
  logic [1:0]  pick_id;
  logic [1:0]  cand;
  logic [2:0]  xfer_num;
  logic [16:0] drop_sum;
  logic [1:0]  rr_next;

  assign drop_mode  = DROP_NO_HOST && !host_presence;
  assign stall_mode = !DROP_NO_HOST && !host_presence;

  // Zero-pad to the 4-requester maximum so indexing by a 2-bit id is always in range.
  assign valid4 = 4'(req_valid);
  assign ready4 = 4'(req_ready);
  assign data4  = 32'(req_data);

  assign grant_byte = data4[{grant_q, 3'b000} +: 8];
  assign grant_xfer = valid4[grant_q] & ready4[grant_q];
  assign rr_next    = (grant_q == 2'(NREQ - 1)) ? 2'd0 : grant_q + 2'd1;
  assign drop_sum   = {1'b0, drop_q} + 17'(xfer_num);

  // Walk offsets from the far end so the nearest valid requester after rr_q wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = 2'd0;
    cand       = 2'd0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      cand = 2'((int'(rr_q) + k) % int'(NREQ));
      if (valid4[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (drop_mode && (state_q == StIdle || state_q == StGrant)) begin
      req_ready = '1;
    end else if (state_q == StGrant && host_presence && !uart_busy) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        req_ready[i] = (grant_q == 2'(i));
      end
    end
  end

  always_comb begin
    xfer_num = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      xfer_num = xfer_num + 3'(req_valid[i] & req_ready[i]);
    end
  end

  always_ff @(posedge clk_48mhz or negedge resetq) begin
    if (!resetq) begin
      state_q   <= StIdle;
      grant_q   <= 2'd0;
      rr_q      <= 2'd0;
      burst_q   <= 8'd0;
      idle_q    <= '0;
      release_q <= 1'b0;
      wr_q      <= 1'b0;
      data_q    <= 8'h00;
      drop_q    <= 16'h0000;
    end else begin
      wr_q <= 1'b0;
      if (drop_mode) begin
        drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
      unique case (state_q)
        StIdle: begin
          idle_q <= '0;
          if (host_presence && pick_found) begin
            grant_q <= pick_id;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (drop_mode) begin
            idle_q  <= '0;
            state_q <= StIdle;
          end else if (host_presence) begin
            if (grant_xfer) begin
              wr_q      <= 1'b1;
              data_q    <= grant_byte;
              burst_q   <= burst_q + 8'd1;
              release_q <= (grant_byte == 8'h0A) || (burst_q == 8'(BURST_MAX - 1));
              idle_q    <= '0;
              state_q   <= StPace1;
            end else if (valid4[grant_q]) begin
              idle_q <= '0;
            end else if (idle_q == IdleW'(IDLE_TIMEOUT - 1)) begin
              idle_q  <= '0;
              burst_q <= 8'd0;
              rr_q    <= rr_next;
              state_q <= StIdle;
            end else begin
              idle_q <= idle_q + IdleW'(1);
            end
          end
        end
        StPace1: begin
          if (!stall_mode) begin
            state_q <= StPace2;
          end
        end
        StPace2: begin
          if (!stall_mode) begin
            release_q <= 1'b0;
            if (release_q || drop_mode) begin
              burst_q <= 8'd0;
              state_q <= StIdle;
              if (release_q) begin
                rr_q <= rr_next;
              end
            end else begin
              state_q <= StGrant;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign uart_wr      = wr_q;
  assign uart_tx_data = data_q;
  assign grant_id     = grant_q;
  assign grant_active = (state_q != StIdle) && !drop_mode;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_usb_uart_tx_arb.sv
// Bench for usb_uart_tx_arb: directed scenarios plus randomized line traffic checked
// against a queue-based line round-robin model.
module tb_usb_uart_tx_arb;

  logic        clk_48mhz = 1'b0;
  logic        resetq;
  logic        host_presence;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        uart_wr;
  logic [7:0]  uart_tx_data;
  logic        uart_busy;
  logic [1:0]  grant_id;
  logic        grant_active;
  logic [15:0] drop_count;

  always #5 clk_48mhz = ~clk_48mhz;

  usb_uart_tx_arb #(
    .NREQ        (2),
    .BURST_MAX   (64),
    .IDLE_TIMEOUT(4800),
    .DROP_NO_HOST(1'b1)
  ) u_dut (
    .clk_48mhz    (clk_48mhz),
    .resetq       (resetq),
    .host_presence(host_presence),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .uart_wr      (uart_wr),
    .uart_tx_data (uart_tx_data),
    .uart_busy    (uart_busy),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .drop_count   (drop_count)
  );

  int         checks;
  int         errors;
  int         cyc;
  int         last_wr_cyc;
  int         w;
  int         c0;
  int         b;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_q[$];
  int         wr_cycles[$];
  logic       busy_drv;
  logic [1:0] hs_prev;
  logic [7:0] byte_prev;
  logic       drop_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rand_char();
    return 8'($urandom_range(32'h20, 32'h7E));
  endfunction

  task automatic drive();
    req_valid[0]   = (q0.size() != 0);
    req_data[7:0]  = (q0.size() != 0) ? q0[0] : 8'h00;
    req_valid[1]   = (q1.size() != 0);
    req_data[15:8] = (q1.size() != 0) ? q1[0] : 8'h00;
    uart_busy      = busy_drv;
  endtask

  // One clock: check outputs at the falling edge, then update requesters after the rise.
  task automatic cycle();
    logic [1:0] hs;
    @(negedge clk_48mhz);
    hs = req_valid & req_ready;
    chk("wr_follows_xfer", 32'(uart_wr), 32'((hs_prev != 2'b00) && !drop_prev));
    if (host_presence) begin
      chk("ready_onehot_not_busy",
          32'(($countones(req_ready) <= 1) && !(uart_busy && (req_ready != 2'b00))), 32'd1);
    end
    if (uart_wr) begin
      chk("wr_data_matches_xfer", 32'(uart_tx_data), 32'(byte_prev));
      chk("wr_spacing", 32'((cyc - last_wr_cyc) >= 3), 32'd1);
      chk("wr_was_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("wr_byte_order", 32'(uart_tx_data), 32'(exp_q.pop_front()));
      last_wr_cyc = cyc;
      wr_cycles.push_back(cyc);
    end
    hs_prev   = hs;
    byte_prev = hs[0] ? req_data[7:0] : req_data[15:8];
    drop_prev = !host_presence;
    @(posedge clk_48mhz);
    cyc++;
    #1;
    if (hs[0]) void'(q0.pop_front());
    if (hs[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    resetq        = 1'b0;
    host_presence = 1'b1;
    busy_drv      = 1'b0;
    q0.delete();
    q1.delete();
    exp_q.delete();
    wr_cycles.delete();
    hs_prev   = 2'b00;
    drop_prev = 1'b0;
    drive();
    repeat (2) @(posedge clk_48mhz);
    #1;
    resetq      = 1'b1;
    last_wr_cyc = -100;
  endtask

  task automatic run_until_drained(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_wr(input int n, input int budget);
    for (int i = 0; i < budget && wr_cycles.size() < n; i++) cycle();
    chk("wr_seen_in_budget", 32'(wr_cycles.size() >= n), 32'd1);
  endtask

  // Line-granular round-robin: alternate whole lines, skipping a requester with nothing left.
  task automatic build_rr_expect();
    logic [7:0] m0[$];
    logic [7:0] m1[$];
    logic [7:0] bt;
    int         p;
    int         pick;
    m0 = q0;
    m1 = q1;
    p  = 0;
    while (m0.size() != 0 || m1.size() != 0) begin
      if (p == 0) pick = (m0.size() != 0) ? 0 : 1;
      else        pick = (m1.size() != 0) ? 1 : 0;
      do begin
        if (pick == 0) bt = m0.pop_front();
        else           bt = m1.pop_front();
        exp_q.push_back(bt);
      end while (bt != 8'h0A);
      p = 1 - pick;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    last_wr_cyc   = -100;
    busy_drv      = 1'b0;
    host_presence = 1'b1;
    resetq        = 1'b0;
    hs_prev       = 2'b00;
    byte_prev     = 8'h00;
    drop_prev     = 1'b0;
    drive();
    repeat (2) @(posedge clk_48mhz);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_uart_wr", 32'(uart_wr), 32'd0);
    chk("reset_tx_data", 32'(uart_tx_data), 32'd0);
    chk("reset_grant_id", 32'(grant_id), 32'd0);
    chk("reset_grant_active", 32'(grant_active), 32'd0);
    chk("reset_drop_count", 32'(drop_count), 32'd0);
    resetq = 1'b1;

    // "AB\n" from requester 0: one-cycle grant latency, writes 3 cycles apart.
    q0    = '{8'h41, 8'h42, 8'h0A};
    exp_q = q0;
    c0    = cyc;
    drive();
    wait_wr(3, 40);
    if (wr_cycles.size() == 3) begin
      chk("ab_first_wr_latency", 32'(wr_cycles[0]), 32'(c0 + 2));
      chk("ab_gap1", 32'(wr_cycles[1] - wr_cycles[0]), 32'd3);
      chk("ab_gap2", 32'(wr_cycles[2] - wr_cycles[1]), 32'd3);
    end
    chk("ab_active_in_pace", 32'(grant_active), 32'd1);
    chk("ab_grant_id", 32'(grant_id), 32'd0);
    cycle();
    chk("ab_released", 32'(grant_active), 32'd0);
    chk("ab_grant_id_kept", 32'(grant_id), 32'd0);

    // Random lines from both requesters with random busy.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int l = 0; l < 5; l++) begin
        int len = $urandom_range(0, 6);
        for (int k = 0; k < len; k++) begin
          if (r == 0) q0.push_back(rand_char());
          else        q1.push_back(rand_char());
        end
        if (r == 0) q0.push_back(8'h0A);
        else        q1.push_back(8'h0A);
      end
    end
    build_rr_expect();
    drive();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
      busy_drv = ($urandom_range(0, 3) == 0);
      cycle();
    end
    chk("rr_lines_drained", 32'(exp_q.size()), 32'd0);
    busy_drv = 1'b0;

    // Burst limit: 70 unterminated bytes from requester 1 break after 64.
    do_reset();
    for (int i = 0; i < 70; i++) q1.push_back(rand_char());
    for (int i = 0; i < 64; i++) exp_q.push_back(q1[i]);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h0A);
    for (int i = 64; i < 70; i++) exp_q.push_back(q1[i]);
    drive();
    repeat (3) cycle();
    q0 = '{8'h5A, 8'h0A};
    run_until_drained("burst_drained", 600);

    // Idle release after 4800 low cycles on the granted port.
    do_reset();
    q0    = '{8'h41};
    exp_q = q0;
    drive();
    wait_wr(1, 20);
    w = (wr_cycles.size() != 0) ? wr_cycles[0] : 0;
    q1 = '{8'h58, 8'h0A};
    exp_q.push_back(8'h58);
    exp_q.push_back(8'h0A);
    run_until_drained("idle_drained", 5200);
    if (wr_cycles.size() >= 2) chk("idle_release_4800", 32'(wr_cycles[1]), 32'(w + 4804));

    // 4799 low cycles then valid again: no release, requester 0 keeps the line.
    do_reset();
    q0    = '{8'h43};
    q1    = '{8'h59, 8'h0A};
    exp_q = '{8'h43, 8'h44, 8'h0A, 8'h59, 8'h0A};
    drive();
    wait_wr(1, 20);
    w = (wr_cycles.size() != 0) ? wr_cycles[0] : 0;
    while (cyc < w + 4800) cycle();
    q0.push_back(8'h44);
    q0.push_back(8'h0A);
    run_until_drained("no_release_drained", 100);
    if (wr_cycles.size() >= 2) chk("no_release_4799", 32'(wr_cycles[1]), 32'(w + 4802));

    // Busy held during GRANT stalls the transfer; send on first busy-low cycle.
    do_reset();
    busy_drv = 1'b1;
    q0       = '{8'h45, 8'h0A};
    exp_q    = q0;
    drive();
    cycle();
    for (int i = 0; i < 100; i++) begin
      cycle();
      chk("busy_stall", 32'({req_ready, uart_wr}), 32'd0);
    end
    busy_drv = 1'b0;
    b        = cyc;
    drive();
    run_until_drained("busy_drained", 20);
    if (wr_cycles.size() != 0) chk("busy_release_wr", 32'(wr_cycles[0]), 32'(b + 1));
    repeat (2) cycle();

    // No host: bytes from both requesters are accepted and counted, never written.
    host_presence = 1'b0;
    for (int i = 0; i < 5; i++) begin
      q0.push_back(rand_char());
      q1.push_back(rand_char());
    end
    drive();
    repeat (8) cycle();
    chk("drop_count_10", 32'(drop_count), 32'd10);
    chk("drop_all_accepted", 32'(q0.size() + q1.size()), 32'd0);
    chk("drop_grant_inactive", 32'(grant_active), 32'd0);

    // Host returns; reset asserted while the write strobe is in flight.
    host_presence = 1'b1;
    q0    = '{8'h46, 8'h0A};
    exp_q = q0;
    drive();
    for (int i = 0; i < 10 && q0.size() == 2; i++) cycle();
    chk("pace_wr_high", 32'(uart_wr), 32'd1);
    chk("pace_drop_kept", 32'(drop_count), 32'd10);
    resetq = 1'b0;
    #1;
    chk("reset_squash_wr", 32'(uart_wr), 32'd0);
    chk("reset_drop_clear", 32'(drop_count), 32'd0);
    chk("reset_grant_active", 32'(grant_active), 32'd0);
    do_reset();
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_uart_tx_arb.md
Name: usb_uart_tx_arb

Overview:
- Shares the single transmit byte interface of the USB CDC UART (uart_wr / uart_tx_data / uart_busy) between NREQ independent byte producers, e.g. the Forth console and a trace/debug stream.
- Arbitration is line-granular round-robin, so characters from different sources never interleave inside a text line.
- Also paces uart_wr against uart_busy and discards traffic while no USB host is present.
- Sits between the requesters and usb_uart, in the 48 MHz domain.

Parameters:
- NREQ, 2: number of requesters; legal range 2..4.
- BURST_MAX, 64: maximum bytes per grant before forced release; range 1..255.
- IDLE_TIMEOUT, 4800: consecutive cycles of req_valid low on the granted port before release (100 us at 48 MHz).
- DROP_NO_HOST, 1: 1 = accept and discard bytes while host_presence is low; 0 = stall.

Ports:
- clk_48mhz  input  1  system clock, 48 MHz.
- resetq  input  1  asynchronous active-low reset.
- host_presence  input  1  from usb_uart; high while the host has the port configured.
- req_valid  input  NREQ  per-requester byte-valid.
- req_data  input  8*NREQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_ready  output  NREQ  per-requester accept.
- uart_wr  output  1  single-cycle write strobe to usb_uart.
- uart_tx_data  output  8  byte to usb_uart; valid while uart_wr is high.
- uart_busy  input  1  from usb_uart; high = cannot accept a write.
- grant_id  output  2  index of the current or last grantee.
- grant_active  output  1  high while in GRANT or PACE.
- drop_count  output  16  count of discarded bytes, saturating.

Behaviour:
- Reset (resetq low, asynchronous):
  - State IDLE; req_ready=0, uart_wr=0, uart_tx_data=0x00, grant_id=0, grant_active=0, drop_count=0.
  - RR pointer=0, burst count=0, idle count=0.
  - A pending uart_wr is squashed. Reset mid-burst requires no recovery by requesters beyond re-presenting their data.
- Transfer rule: a byte moves from requester i on any cycle where req_valid[i] and req_ready[i] are both high. req_ready is combinational from state and uart_busy. Requesters must hold req_data stable while valid and not ready.
- State IDLE:
  - Priority order is rotating, starting at the RR pointer.
  - The first index with req_valid high is registered into grant_id; the next cycle is GRANT.
  - Grant latency is one cycle. No req_ready is asserted in IDLE.
- State GRANT:
  - req_ready[grant_id] = ~uart_busy; all other req_ready bits are 0.
  - On transfer at cycle t: uart_wr=1 and uart_tx_data=byte at t+1, for exactly one cycle. The burst count increments and the state moves to PACE.
- State PACE:
  - Lasts 2 cycles (t+1, t+2), req_ready=0 throughout. This covers uart_busy rising one cycle after uart_wr.
  - Returns to GRANT, or to IDLE if a release condition was met. The earliest next transfer from the same requester is t+3.
  - Sustained throughput is at most 1 byte per 3 cycles.
- Release (checked on the transfer cycle; effective after PACE):
  - The byte equals 0x0A, or
  - the burst count reaches BURST_MAX.
  - On release: RR pointer = grant_id+1 modulo NREQ, and the burst count clears.
- Idle release: in GRANT, if req_valid[grant_id] stays low for IDLE_TIMEOUT consecutive cycles, go to IDLE with the same RR pointer update. The idle counter clears on any cycle with valid high.
- A requester deasserting valid without a transfer is legal; no byte is lost.
- No-host handling, DROP_NO_HOST=1, host_presence low:
  - PACE completes normally; then go to IDLE.
  - In IDLE and GRANT, req_ready is all-ones and uart_wr is never asserted.
  - drop_count increments by the number of bytes transferred that cycle, saturating at 0xFFFF. grant_active=0.
- No-host handling, DROP_NO_HOST=0: req_ready is forced to 0 while host_presence is low; state is held.
- host_presence rising while in IDLE resumes normal arbitration on the next cycle.
- uart_busy high for arbitrarily long in GRANT stalls indefinitely; the idle timer does not run while req_valid is high.

Test Plan:
- Requester 0 sends "AB\n" with busy=0 → uart_wr pulses 3 cycles apart carrying 0x41, 0x42, 0x0A; grant_active drops after the last PACE; grant_id=0.
- Requesters 0 and 1 both stream lines continuously from reset → output lines alternate 0,1,0,1; no byte of requester 1 appears before requester 0's 0x0A.
- BURST_MAX=4; requester 1 sends 10 bytes with no newline while requester 0 is also valid → 4 bytes from 1, then requester 0 is granted.
- Granted requester stops mid-line with valid low for 4800 cycles while another is valid → release at cycle 4800, other requester granted; with 4799 idle cycles followed by valid → no release.
- Hold uart_busy=1 for 100 cycles during GRANT → req_ready=0 and no uart_wr throughout; the byte is sent at the first busy-low cycle, with uart_wr one cycle later.
- host_presence=0, DROP_NO_HOST=1, both requesters push 5 bytes each → uart_wr never asserts, drop_count=10. Assert resetq low mid-PACE → uart_wr and drop_count return to 0 immediately.
